// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single main-memory port between three vscpu cores and the UART host bridge
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   req_i, we_i         per-requester request / write enable; [0] codemaker, [1] control tower, [2] agent_1, [3] host
//   addr_i, wdata_i     packed per-requester address / write data, slice i = [i*W +: W]
//   gnt_o               one-hot pulse in the cycle the access is issued to memory
//   rvalid_o            one-hot pulse when the access completes (rdata_o valid for reads)
//   rdata_o             registered read data shared by all requesters, unchanged by writes
//   busy_o              an access is in flight
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o   registered memory port
//   mem_rdata_i         memory read data, valid one cycle after mem_en_o
module mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int HOST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req_i,
    input  logic [3:0]          we_i,
    input  logic [4*ADDR_W-1:0] addr_i,
    input  logic [4*DATA_W-1:0] wdata_i,
    output logic [3:0]          gnt_o,
    output logic [3:0]          rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                busy_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int HC_W = $clog2(HOST_MAX + 1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(HOST_MAX);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state_q, state_d;
    logic [1:0] win_q, win_d, rr_q, rr_d, cpu_w, win, idx;
    logic [HC_W-1:0] hc_q, hc_d;
    logic [3:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic we_q, we_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic cpu_any, host_win, found;
    logic [ADDR_W-1:0] addr_a [4];
    logic [DATA_W-1:0] wdata_a [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign addr_a[i]  = addr_i[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = wdata_i[i*DATA_W +: DATA_W];
    end

    assign cpu_any  = |req_i[2:0];
    // The host yields only after HOST_MAX back-to-back grants taken while a CPU was waiting.
    assign host_win = req_i[3] && !(hc_q == HC_MAX && cpu_any);

    // Round-robin among CPUs, starting one past the last CPU served.
    always_comb begin
        cpu_w = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(rr_q) + k) % 3);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                cpu_w = idx;
            end
        end
    end

    assign win = host_win ? 2'd3 : cpu_w;

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        rr_d        = rr_q;
        hc_d        = hc_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: if (|req_i) begin
                state_d     = ISSUE;
                win_d       = win;
                we_d        = we_i[win];
                gnt_d       = 4'b0001 << win;
                mem_en_d    = 1'b1;
                mem_we_d    = we_i[win];
                mem_addr_d  = addr_a[win];
                mem_wdata_d = wdata_a[win];
                rr_d        = (win == 2'd3) ? rr_q : win;
                // A host win with a CPU waiting implies hc_q < HOST_MAX, so this saturates by construction.
                hc_d        = (win == 2'd3 && cpu_any) ? hc_q + 1'b1 : '0;
            end
            ISSUE: state_d = RESP;
            RESP: begin
                state_d  = IDLE;
                rvalid_d = 4'b0001 << win_q;
                rdata_d  = we_q ? rdata_q : mem_rdata_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_q       <= 2'd0;
            we_q        <= 1'b0;
            rr_q        <= 2'd2;
            hc_q        <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            rr_q        <= rr_d;
            hc_q        <= hc_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = state_q != IDLE;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a timeline-level reference model of the memory port arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int HOST_MAX = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [3:0]          req = '0;
    logic [3:0]          we = '0;
    logic [4*ADDR_W-1:0] addr = '0;
    logic [4*DATA_W-1:0] wdata = '0;
    logic [3:0]          gnt, rvalid;
    logic [DATA_W-1:0]   rdata, mem_wdata;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                busy, mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX(HOST_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-up memory contents: 0x203E holds 7, everything else a recognisable pattern.
    function automatic logic [31:0] init_val(int a);
        return (a == 'h203E) ? 32'd7 : (32'hC0DE0000 | 32'(a));
    endfunction

    // Synchronous memory seen by the DUT: read data one cycle after mem_en.
    logic [31:0] ram_w [int];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram_w.exists(int'(mem_addr)) ? ram_w[int'(mem_addr)] : init_val(int'(mem_addr));
            if (mem_we) ram_w[int'(mem_addr)] = mem_wdata;
        end
    end

    // Reference model: each accepted access at sampling cycle tt owns the timeline tt+1..tt+3.
    int cyc = 0, tt = -100, free = 0, who = 0, m_rr = 2, m_hc = 0, pick = 0;
    logic twe = 1'b0, cpu_wait = 1'b0;
    logic [ADDR_W-1:0] taddr = '0, e_addr = '0;
    logic [DATA_W-1:0] twdata = '0, e_wdata = '0, e_rdata = '0;
    logic [31:0] m_mem [int];
    logic [3:0] oh;

    function automatic logic [31:0] m_read(int a);
        return m_mem.exists(a) ? m_mem[a] : init_val(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt = -100; free = 0; m_rr = 2; m_hc = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else begin
            if (cyc == tt + 1 && twe) m_mem[int'(taddr)] = twdata;
            if (cyc == tt + 2 && !twe) e_rdata = m_read(int'(taddr));
            if (cyc >= free && req != 4'b0) begin
                cpu_wait = |req[2:0];
                if (req[3] && !(m_hc >= HOST_MAX && cpu_wait)) begin
                    who = 3;
                    m_hc = cpu_wait ? m_hc + 1 : 0;
                end else begin
                    pick = -1;
                    for (int d = 1; d <= 3; d++)
                        if (pick < 0 && req[(m_rr + d) % 3]) pick = (m_rr + d) % 3;
                    who = pick; m_rr = pick; m_hc = 0;
                end
                twe = we[who];
                taddr = addr[who*ADDR_W +: ADDR_W];
                twdata = wdata[who*DATA_W +: DATA_W];
                e_addr = taddr; e_wdata = twdata;
                tt = cyc; free = cyc + 3;
            end
            cyc++;
        end
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        oh = 4'b0001 << who;
        chk("gnt", {60'd0, gnt}, (cyc == tt + 1) ? {60'd0, oh} : 64'd0);
        chk("rvalid", {60'd0, rvalid}, (cyc == tt + 3) ? {60'd0, oh} : 64'd0);
        chk("busy", {63'd0, busy}, {63'd0, cyc == tt + 1 || cyc == tt + 2});
        chk("mem_en", {63'd0, mem_en}, {63'd0, cyc == tt + 1});
        chk("mem_we", {63'd0, mem_we}, {63'd0, cyc == tt + 1 && twe});
        chk("mem_addr", {50'd0, mem_addr}, {50'd0, e_addr});
        chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wdata});
        chk("rdata", {32'd0, rdata}, {32'd0, e_rdata});
    end

    task automatic wait_gnt(output logic [3:0] g, output int c);
        g = '0; c = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                g = gnt; c = cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL gnt_timeout: no grant within 30 cycles, one required");
    endtask

    logic [3:0] g;
    int c, lc;
    logic [3:0] exp3 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    logic [3:0] exp4 [10] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h2, 4'h8, 4'h8, 4'h8, 4'h8, 4'h2};
    logic [3:0] exp5 [4] = '{4'h8, 4'h1, 4'h2, 4'h4};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", {60'd0, gnt}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        rst_n = 1'b1;
        // Host read of 0x203E
        addr[3*ADDR_W +: ADDR_W] = 14'h203E;
        req = 4'b1000;
        wait_gnt(g, c);
        chk("s1_gnt", {60'd0, g}, 64'h8);
        chk("s1_mem_en", {63'd0, mem_en}, 64'd1);
        chk("s1_mem_addr", {50'd0, mem_addr}, 64'h203E);
        chk("s1_mem_we", {63'd0, mem_we}, 64'd0);
        req = 4'b0;
        repeat (2) @(negedge clk);
        chk("s1_rvalid", {60'd0, rvalid}, 64'h8);
        chk("s1_rdata", {32'd0, rdata}, 64'd7);
        chk("s1_busy", {63'd0, busy}, 64'd0);
        // Host write of 0 to 0x203E, then read it back
        we[3] = 1'b1;
        wdata[3*DATA_W +: DATA_W] = 32'h0;
        req = 4'b1000;
        wait_gnt(g, c);
        chk("s2_mem_we", {63'd0, mem_we}, 64'd1);
        req = 4'b0;
        repeat (2) @(negedge clk);
        chk("s2_rvalid", {60'd0, rvalid}, 64'h8);
        chk("s2_rdata_kept", {32'd0, rdata}, 64'd7);
        we[3] = 1'b0;
        req = 4'b1000;
        wait_gnt(g, c);
        req = 4'b0;
        repeat (2) @(negedge clk);
        chk("s2_readback", {32'd0, rdata}, 64'd0);
        // Three CPUs held high: round-robin from CPU0, one grant every 3 cycles
        addr[0*ADDR_W +: ADDR_W] = 14'h0010;
        addr[1*ADDR_W +: ADDR_W] = 14'h0020;
        addr[2*ADDR_W +: ADDR_W] = 14'h0030;
        wdata[1*DATA_W +: DATA_W] = 32'hDEADBEEF;
        we = 4'b0010;
        req = 4'b0111;
        lc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, c);
            chk($sformatf("s3_gnt%0d", i), {60'd0, g}, {60'd0, exp3[i]});
            if (i > 0) chk($sformatf("s3_gap%0d", i), 64'(c - lc), 64'd3);
            lc = c;
        end
        req = 4'b0;
        repeat (3) @(negedge clk);
        // Host and CPU1 held high: host capped at HOST_MAX consecutive grants
        we = 4'b0;
        req = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            wait_gnt(g, c);
            chk($sformatf("s4_gnt%0d", i), {60'd0, g}, {60'd0, exp4[i]});
        end
        req = 4'b0;
        repeat (2) @(negedge clk);
        chk("s4_rdata", {32'd0, rdata}, 64'hDEADBEEF);
        repeat (2) @(negedge clk);
        // All four from reset: host once, then CPU0, CPU1, CPU2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, c);
            if (g == 4'b1000) req[3] = 1'b0;
            chk($sformatf("s5_gnt%0d", i), {60'd0, g}, {60'd0, exp5[i]});
            chk($sformatf("s5_onehot%0d", i), {63'd0, $onehot(g)}, 64'd1);
        end
        req = 4'b0;
        repeat (3) @(negedge clk);
        // Reset during the RESP cycle of a CPU2 read aborts it
        req = 4'b0100;
        wait_gnt(g, c);
        chk("s6_gnt_cpu2", {60'd0, g}, 64'h4);
        req = 4'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", {63'd0, busy}, 64'd0);
        chk("s6_rst_mem_addr", {50'd0, mem_addr}, 64'd0);
        chk("s6_rst_rdata", {32'd0, rdata}, 64'd0);
        chk("s6_rst_rvalid", {60'd0, rvalid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("s6_no_rvalid", {60'd0, rvalid}, 64'd0);
        end
        req = 4'b0111;
        wait_gnt(g, c);
        chk("s6_gnt_cpu0", {60'd0, g}, 64'h1);
        req = 4'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
